// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the 7-segment driver.
// Table is active-high (1 = lit), bit 6 = a ... bit 0 = g.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = '0;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] h);
        logic [SEG_W-1:0] s;
        unique case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to 7-segment decoder, active-high output.
// Ports: i_Hex (nibble in), o_Seg (segments a..g, a = bit 6).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0]       i_Hex,
    output logic [SEG_W-1:0] o_Seg
);

    assign o_Seg = hex_to_seg(i_Hex);

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver: double-buffered hex word, one digit
// per refresh slot, leading-zero blanking, per-digit dp, global enable.
// Ports: i_Clk/i_Rst (sync, active-high), i_Data/i_Dp/i_Load (pending
// buffer write), i_Enable, i_Blank_LZ; o_Segmentos/o_Dp/o_Anodos (registered
// pin drive), o_Busy (pending not yet shown), o_Frame (frame boundary pulse).
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [4*N_DIGITS-1:0] i_Data,
    input  logic [N_DIGITS-1:0]   i_Dp,
    input  logic                  i_Load,
    input  logic                  i_Enable,
    input  logic                  i_Blank_LZ,
    output logic [SEG_W-1:0]      o_Segmentos,
    output logic                  o_Dp,
    output logic [N_DIGITS-1:0]   o_Anodos,
    output logic                  o_Busy,
    output logic                  o_Frame
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(REFRESH_DIV - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]    SEG_IDLE = SEG_OFF ^ {SEG_W{SEG_POL}};
    localparam logic [N_DIGITS-1:0] AN_IDLE  = {N_DIGITS{AN_POL}};

    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    logic [4*N_DIGITS-1:0]   pend_data_q, disp_data_q;
    logic [N_DIGITS-1:0]     pend_dp_q, disp_dp_q;
    logic                    busy_q, frame_q;
    logic [SEG_W-1:0]        seg_q;
    logic                    dp_q;
    logic [N_DIGITS-1:0]     an_q;

    logic                    tick, boundary;
    logic [N_DIGITS-1:0]     upper_zero;
    logic [3:0]              sel_nib;
    logic                    sel_dp, sel_zero, blank;
    logic [N_DIGITS-1:0]     sel_oh;
    logic [SEG_W-1:0]        dec_seg;
    logic [SEG_W-1:0]        seg_d;
    logic                    dp_d, frame_d;
    logic [N_DIGITS-1:0]     an_d;

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    // Predict the boundary one cycle early so o_Frame is high during it.
    assign frame_d  = (cnt_q == CNT_PRE) && (idx_q == IDX_LAST);

    // upper_zero[k]: display nibbles k..N_DIGITS-1 are all zero.
    always_comb begin : lz_scan
        logic z;
        z = 1'b1;
        upper_zero = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            z = z & (disp_data_q[4*k +: 4] == 4'h0);
            upper_zero[k] = z;
        end
    end

    always_comb begin
        sel_nib  = '0;
        sel_dp   = 1'b0;
        sel_zero = 1'b0;
        sel_oh   = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_nib   = disp_data_q[4*k +: 4];
                sel_dp    = disp_dp_q[k];
                sel_zero  = upper_zero[k];
                sel_oh[k] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_dec (
        .i_Hex (sel_nib),
        .o_Seg (dec_seg)
    );

    assign blank = i_Blank_LZ && sel_zero && (idx_q != '0);
    assign seg_d = ((i_Enable && !blank) ? dec_seg : SEG_OFF)
                   ^ {SEG_W{SEG_POL}};
    assign dp_d  = (i_Enable && sel_dp) ^ SEG_POL;
    assign an_d  = (i_Enable ? sel_oh : '0) ^ AN_IDLE;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            busy_q      <= 1'b0;
            frame_q     <= 1'b0;
            seg_q       <= SEG_IDLE;
            dp_q        <= SEG_POL;
            an_q        <= AN_IDLE;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
            if (i_Load) begin
                pend_data_q <= i_Data;
                pend_dp_q   <= i_Dp;
            end
            // Transfer uses the old pending value; a same-cycle load waits.
            if (boundary && busy_q) begin
                disp_data_q <= pend_data_q;
                disp_dp_q   <= pend_dp_q;
            end
            busy_q  <= i_Load | (busy_q & ~boundary);
            frame_q <= frame_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign o_Segmentos = seg_q;
    assign o_Dp        = dp_q;
    assign o_Anodos    = an_q;
    assign o_Busy      = busy_q;
    assign o_Frame     = frame_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver, N_DIGITS=4, REFRESH_DIV=4,
// active-low segments and anodes.
module tb_seg7_mux_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic        en;
    logic        blz;
    logic [6:0]  segs;
    logic        odp;
    logic [3:0]  an;
    logic        busy;
    logic        frame;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_mux_driver #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Data      (data),
        .i_Dp        (dp),
        .i_Load      (load),
        .i_Enable    (en),
        .i_Blank_LZ  (blz),
        .o_Segmentos (segs),
        .o_Dp        (odp),
        .o_Anodos    (an),
        .o_Busy      (busy),
        .o_Frame     (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] an_sel(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return 4'b1111 ^ (one << k);
    endfunction

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Load at a frame negedge, then wait for the boundary that transfers it.
    task automatic load_and_show(input logic [15:0] d, input logic [3:0] p);
        bit ok;
        data = d;
        dp   = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame(ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL load_frame_timeout: got %b expected 1", ok);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; data = '0; dp = '0; load = 1'b0; en = 1'b1; blz = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (segs !== 7'b1111111) begin
            n_bad++; $display("FAIL rst_segs: got %b expected 1111111", segs);
        end
        n_cmp++;
        if (an !== 4'b1111) begin
            n_bad++; $display("FAIL rst_an: got %b expected 1111", an);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (frame !== 1'b0) begin
            n_bad++; $display("FAIL rst_frame: got %b expected 0", frame);
        end
        n_cmp++;
        if (odp !== 1'b1) begin
            n_bad++; $display("FAIL rst_dp: got %b expected 1", odp);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({an, segs} !== {4'b1110, 7'b0000001}) begin
            n_bad++;
            $display("FAIL rst_first_digit: got %b expected %b",
                     {an, segs}, {4'b1110, 7'b0000001});
        end
    endtask

    task automatic test_scan;
        logic [6:0] exp_seg [4];
        bit ok;
        int k;
        exp_seg[0] = 7'b0111000;
        exp_seg[1] = 7'b0001000;
        exp_seg[2] = 7'b0010010;
        exp_seg[3] = 7'b1001111;
        data = 16'h12AF; dp = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL scan_busy_set: got %b expected 1", busy);
        end
        wait_frame(ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++; $display("FAIL scan_frame_timeout: got %b expected 1", ok);
        end
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++; $display("FAIL scan_busy_clr: got %b expected 0", busy);
                end
            end
            if (t % 4 == 2) begin
                k = (t - 2) / 4;
                n_cmp++;
                if ({an, segs} !== {an_sel(k), exp_seg[k]}) begin
                    n_bad++;
                    $display("FAIL scan_digit%0d: got %b expected %b",
                             k, {an, segs}, {an_sel(k), exp_seg[k]});
                end
            end
            if (t == 8) begin
                n_cmp++;
                if (frame !== 1'b0) begin
                    n_bad++; $display("FAIL scan_frame_mid: got %b expected 0", frame);
                end
            end
        end
        n_cmp++;
        if (frame !== 1'b1) begin
            n_bad++; $display("FAIL scan_frame_period: got %b expected 1", frame);
        end
    endtask

    task automatic test_double_buffer;
        int k;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            load = 1'b0;
            if (t == 3) begin data = 16'h1111; load = 1'b1; end
            if (t == 5) begin data = 16'h2222; load = 1'b1; end
        end
        n_cmp++;
        if ({frame, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL dbuf_busy_at_frame: got %b expected 11", {frame, busy});
        end
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t % 4 == 2) begin
                k = (t - 2) / 4;
                n_cmp++;
                if ({an, segs} !== {an_sel(k), 7'b0010010}) begin
                    n_bad++;
                    $display("FAIL dbuf_digit%0d: got %b expected %b",
                             k, {an, segs}, {an_sel(k), 7'b0010010});
                end
            end
        end
    endtask

    task automatic test_load_on_boundary;
        data = 16'h3333; load = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            load = 1'b0;
            if (t == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++; $display("FAIL lob_busy_held: got %b expected 1", busy);
                end
            end
            if (t == 2) begin
                n_cmp++;
                if (segs !== 7'b0010010) begin
                    n_bad++; $display("FAIL lob_old_data: got %b expected 0010010", segs);
                end
            end
        end
        n_cmp++;
        if ({frame, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL lob_busy_frame: got %b expected 11", {frame, busy});
        end
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++; $display("FAIL lob_busy_clr: got %b expected 0", busy);
                end
            end
            if (t == 2 || t == 14) begin
                n_cmp++;
                if ({an, segs} !== {an_sel((t - 2) / 4), 7'b0000110}) begin
                    n_bad++;
                    $display("FAIL lob_new_data_t%0d: got %b expected %b", t,
                             {an, segs}, {an_sel((t - 2) / 4), 7'b0000110});
                end
            end
        end
    endtask

    task automatic test_lz;
        logic [11:0] exp_a [4];
        logic [11:0] exp_b [4];
        int k;
        exp_a[0] = {1'b1, 4'b1110, 7'b0000001};
        exp_a[1] = {1'b1, 4'b1101, 7'b0100100};
        exp_a[2] = {1'b1, 4'b1011, 7'b1111111};
        exp_a[3] = {1'b0, 4'b0111, 7'b1111111};
        exp_b[0] = {1'b1, 4'b1110, 7'b0000001};
        exp_b[1] = {1'b1, 4'b1101, 7'b1111111};
        exp_b[2] = {1'b1, 4'b1011, 7'b1111111};
        exp_b[3] = {1'b1, 4'b0111, 7'b1111111};
        blz = 1'b1;
        load_and_show(16'h0050, 4'b1000);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t % 4 == 2) begin
                k = (t - 2) / 4;
                n_cmp++;
                if ({odp, an, segs} !== exp_a[k]) begin
                    n_bad++;
                    $display("FAIL lz_0050_digit%0d: got %b expected %b",
                             k, {odp, an, segs}, exp_a[k]);
                end
            end
        end
        load_and_show(16'h0000, 4'b0000);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t % 4 == 2) begin
                k = (t - 2) / 4;
                n_cmp++;
                if ({odp, an, segs} !== exp_b[k]) begin
                    n_bad++;
                    $display("FAIL lz_0000_digit%0d: got %b expected %b",
                             k, {odp, an, segs}, exp_b[k]);
                end
            end
        end
    endtask

    task automatic test_enable;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 2) begin
                n_cmp++;
                if (an !== 4'b1110) begin
                    n_bad++; $display("FAIL en_before: got %b expected 1110", an);
                end
                en = 1'b0;
            end
            if (t == 3 || t == 11) begin
                n_cmp++;
                if ({odp, an, segs} !== 12'b1_1111_1111111) begin
                    n_bad++;
                    $display("FAIL en_dark_t%0d: got %b expected 111111111111",
                             t, {odp, an, segs});
                end
            end
            if (t == 12) en = 1'b1;
            if (t == 13) begin
                n_cmp++;
                if (an !== 4'b1011) begin
                    n_bad++; $display("FAIL en_resume: got %b expected 1011", an);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        blz = 1'b0;
        load_and_show(16'h4444, 4'b0000);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            load = 1'b0;
            if (t == 2) begin
                n_cmp++;
                if ({an, segs} !== {4'b1110, 7'b1001100}) begin
                    n_bad++;
                    $display("FAIL rmid_shows4: got %b expected %b",
                             {an, segs}, {4'b1110, 7'b1001100});
                end
            end
            if (t == 8) begin data = 16'h5555; load = 1'b1; end
            if (t == 9) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++; $display("FAIL rmid_busy: got %b expected 1", busy);
                end
            end
            if (t == 10) rst = 1'b1;
            if (t == 11) begin
                rst = 1'b0;
                n_cmp++;
                if ({busy, frame, an, segs} !== {2'b00, 4'b1111, 7'b1111111}) begin
                    n_bad++;
                    $display("FAIL rmid_after_rst: got %b expected %b",
                             {busy, frame, an, segs}, {2'b00, 4'b1111, 7'b1111111});
                end
            end
            if (t == 12) begin
                n_cmp++;
                if ({an, segs} !== {4'b1110, 7'b0000001}) begin
                    n_bad++;
                    $display("FAIL rmid_cleared: got %b expected %b",
                             {an, segs}, {4'b1110, 7'b0000001});
                end
            end
            if (t == 16) begin
                n_cmp++;
                if ({busy, an} !== {1'b0, 4'b1101}) begin
                    n_bad++;
                    $display("FAIL rmid_index: got %b expected %b",
                             {busy, an}, {1'b0, 4'b1101});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_buffer();
        test_load_on_boundary();
        test_lz();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
Time-multiplexed driver for a bank of N_DIGITS common-anode/cathode 7-segment digits sharing one segment bus. It holds a double-buffered hex word, scans one digit per refresh tick, decodes each nibble to segments (0-F), and adds per-digit decimal point, leading-zero blanking and a global enable. It sits between the datapath, which presents values with a load strobe, and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8).
REFRESH_DIV, 50000, clock cycles per digit slot (>=2); prescaler width = $clog2(REFRESH_DIV).
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs are active-low; 0 = active-high.
AN_ACTIVE_LOW, 1, 1 = digit-select outputs are active-low; 0 = active-high.

Ports:
i_Clk  in  1  system clock; one clock domain.
i_Rst  in  1  synchronous reset, active-high.
i_Data  in  4*N_DIGITS  hex nibbles; nibble k = digit k, digit 0 = least significant (rightmost).
i_Dp  in  N_DIGITS  decimal point request per digit.
i_Load  in  1  single-cycle strobe: capture i_Data/i_Dp into pending buffer.
i_Enable  in  1  0 = all digits dark; scanning continues.
i_Blank_LZ  in  1  1 = blank leading zero digits.
o_Segmentos  out  7  segments {a,b,c,d,e,f,g}, a = bit 6, g = bit 0.
o_Dp  out  1  decimal point of the currently selected digit.
o_Anodos  out  N_DIGITS  one-hot digit select (polarity per AN_ACTIVE_LOW).
o_Busy  out  1  high while the pending buffer awaits transfer.
o_Frame  out  1  one-cycle pulse when a frame boundary occurs.

Behaviour:
- Reset (i_Rst high at a clock edge): prescaler=0, digit index=0, pending and display buffers=0, o_Busy=0, o_Frame=0. o_Segmentos, o_Dp and o_Anodos are driven to the inactive level (all segments off, no digit selected). Reset overrides every other input, including mid-load and mid-frame.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. Tick = the cycle with count == REFRESH_DIV-1.
- On a tick the digit index advances by 1, wrapping N_DIGITS-1 -> 0. The wrap cycle is the frame boundary: o_Frame=1 for exactly that cycle.
- Double buffer: i_Load=1 captures pending <= {i_Dp,i_Data} and sets o_Busy=1. A load while busy overwrites pending (last write wins).
- At a frame boundary with o_Busy=1 (from a previous cycle), display <= pending and o_Busy clears on the next edge. A load coinciding with a boundary goes to pending only: o_Busy stays 1 and the transfer happens at the next boundary.
- Output path is fully registered. Outputs reflect digit index k one cycle after the index becomes k. No combinational path exists from inputs to outputs.
- Decode table, active-high form (1 = lit), bits a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Output is inverted when SEG_ACTIVE_LOW=1, so 0 -> 7'b0000001 and 8 -> 7'b0000000.
- Leading-zero blanking: with i_Blank_LZ=1, digit k is blanked (segments off) if display nibbles k..N_DIGITS-1 are all 0. Digit 0 is never blanked. The dp of a blanked digit is still honoured.
- i_Enable=0: segments, dp and anodes are inactive on the next edge. Prescaler, index and buffers keep running.
- N_DIGITS=1: index stays 0 and every tick is a frame boundary.

Decomposition:
- Shared package seg7_pkg: seg7 width constant (7), the hex->segment table as a function or localparam array in active-high form, and the SEG_OFF constant.
- One sub-module, hex_to_seg7: combinational 4-bit -> 7-bit active-high decoder. The top applies polarity and blanking.

Test Plan:
- Reset: N=4, REFRESH_DIV=4, assert i_Rst for 3 cycles -> o_Segmentos=7'b1111111, o_Anodos=4'b1111, o_Busy=0, o_Frame=0. After release, the first digit select is 4'b1110 one cycle after the first index update.
- Scan and decode: load i_Data=16'h12AF, i_Dp=0 -> after transfer, successive slots show {anodes,segs} = 1110/0111000 (F), 1101/0001000 (A), 1011/0010010 (2), 0111/1001111 (1). Each slot is 4 cycles, and o_Frame pulses once every 16 cycles.
- Double buffer: load 16'h1111, then 16'h2222 two cycles later, mid-frame -> o_Busy=1 until the boundary. All four digits of the next frame show 2, never a mix with 1.
- Load on boundary: i_Load asserted in the o_Frame cycle -> o_Busy stays 1 and new data appears one full frame later.
- Leading-zero blanking: i_Data=16'h0050, i_Blank_LZ=1, i_Dp=4'b1000 -> digits 3 and 2 dark except dp on digit 3 (o_Dp=0), digit 1 shows 5, digit 0 shows 0. With i_Data=16'h0000, only digit 0 is lit, showing 0.
- Enable and reset mid-frame: drop i_Enable for 10 cycles -> o_Anodos=4'b1111, then scanning resumes with the index advanced. Assert i_Rst in slot 2 with o_Busy=1 -> buffers cleared, o_Busy=0, index=0.
